// File: rtl/score_ctrl_pkg.sv
// score_ctrl_pkg: session states and scoring-unit control codes shared by the session controller.
package score_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PLAY, REPORT, DONE, TOP, TOPHOLD} sessState;
  localparam logic [2:0] CTRL_IDLE = 3'd0;
  localparam logic [2:0] CTRL_PLAY = 3'd1;
  localparam logic [2:0] CTRL_REPORT = 3'd3;
  localparam logic [2:0] CTRL_TOP = 3'd4;
  function automatic logic [2:0] ctrlOf(sessState s);
    return s == PLAY ? CTRL_PLAY :
           (s == REPORT || s == DONE) ? CTRL_REPORT :
           (s == TOP || s == TOPHOLD) ? CTRL_TOP : CTRL_IDLE;
  endfunction
endpackage

// File: rtl/bcd_sat_add.sv
// bcd_sat_add: adds 0..9 to a two-digit BCD value, saturating at 99.
module bcd_sat_add (
  input  logic [3:0] onesIn,
  input  logic [3:0] tensIn,
  input  logic [3:0] pts,
  output logic [3:0] onesOut,
  output logic [3:0] tensOut
);
  logic [4:0] sum;
  logic carry, sat;
  assign sum = {1'b0, onesIn} + {1'b0, pts};
  assign carry = sum > 5'd9;
  assign sat = carry && tensIn == 4'd9;
  // sum is 10..18 on carry, so the low nibble minus 10 wraps to the right digit
  assign onesOut = sat ? 4'd9 : carry ? sum[3:0] - 4'd10 : sum[3:0];
  assign tensOut = sat ? 4'd9 : tensIn + {3'b0, carry};
endmodule

// File: rtl/score_session_ctrl.sv
// score_session_ctrl: session sequencer driving the scoring unit with a saturating BCD score.
// Define SCORE_TIMEOUT_EN to end a round with 0 points after TIMEOUT_CYC cycles without round_done.
module score_session_ctrl
  import score_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 5,
  parameter int unsigned HOLD_CYC = 8,
  parameter int unsigned TOP_CYC = 8
`ifdef SCORE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       guest_in,
  input  logic [2:0] user_id_in,
  input  logic       round_done,
  input  logic [3:0] round_pts,
  input  logic       show_top,
  output logic [2:0] ctrl_sig,
  output logic       is_guest,
  output logic [2:0] int_id,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       session_done,
  output logic       top_valid,
  output logic       timeout_o
);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TOP_LAST = 16'(TOP_CYC - 1);
  sessState state, stateNext;
  logic [15:0] holdCnt;
  logic [3:0] ptsClamped, onesSum, tensSum;
  logic timeoutHit, roundEnd;
  assign ptsClamped = !round_done ? 4'd0 : round_pts > 4'd9 ? 4'd9 : round_pts;
  assign roundEnd = state == PLAY && (round_done || timeoutHit);
  bcd_sat_add addU (
    .onesIn(score_ones),
    .tensIn(score_tens),
    .pts(ptsClamped),
    .onesOut(onesSum),
    .tensOut(tensSum)
  );
`ifdef SCORE_TIMEOUT_EN
  logic [31:0] toCnt;
  assign timeoutHit = state == PLAY && !round_done && toCnt == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toCnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      toCnt <= (state != PLAY || round_done || timeoutHit) ? '0 : toCnt + 32'd1;
      timeout_o <= timeoutHit && !abort;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = start ? SETUP : IDLE;
      SETUP:   stateNext = PLAY;
      PLAY:    stateNext = (roundEnd && round_idx + 4'd1 == LAST_ROUND) ? REPORT : PLAY;
      REPORT:  stateNext = holdCnt == HOLD_LAST ? DONE : REPORT;
      DONE:    stateNext = start ? SETUP : show_top ? TOP : DONE;
      TOP:     stateNext = holdCnt == TOP_LAST ? TOPHOLD : TOP;
      TOPHOLD: stateNext = start ? SETUP : TOPHOLD;
      default: stateNext = IDLE;
    endcase
    if (abort) stateNext = IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      holdCnt <= '0;
      ctrl_sig <= CTRL_IDLE;
      is_guest <= 1'b0;
      int_id <= '0;
      score_ones <= '0;
      score_tens <= '0;
      round_idx <= '0;
      busy <= 1'b0;
      session_done <= 1'b0;
      top_valid <= 1'b0;
    end else begin
      state <= stateNext;
      holdCnt <= stateNext != state ? '0 : holdCnt + 16'd1;
      // outputs follow the next state so they are registered yet aligned with it
      ctrl_sig <= ctrlOf(stateNext);
      busy <= stateNext inside {SETUP, PLAY, REPORT, TOP};
      session_done <= stateNext == DONE;
      top_valid <= stateNext == TOPHOLD;
      if (abort) begin
        score_ones <= '0;
        score_tens <= '0;
        round_idx <= '0;
      end else if (stateNext == SETUP && state != SETUP) begin
        is_guest <= guest_in;
        int_id <= user_id_in;
        score_ones <= '0;
        score_tens <= '0;
        round_idx <= '0;
      end else if (roundEnd) begin
        score_ones <= onesSum;
        score_tens <= tensSum;
        round_idx <= round_idx + 4'd1;
      end
    end
  end
endmodule
